// File: rtl/angle_reducer.sv
// rtl/angle_reducer.sv - reduces an integer-degree angle mod 360 to a quadrant code and 0..90 reference angle
// Binary long-division style reduction: one conditional subtract of 360<<k per cycle, k counting down.
module angle_reducer #(
  parameter int ANGLE_W = 16,
  parameter int REF_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ANGLE_W-1:0] angle_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         quadrant,
  output logic [REF_W-1:0]   ref_angle,
  output logic               lut_en
);

  localparam int RW = ANGLE_W + 2;

  // Smallest k such that 360<<(k+1) exceeds the largest input angle.
  function automatic int calc_k0();
    longint unsigned lim;
    int res;
    lim = (64'd1 << ANGLE_W) - 64'd1;
    res = 31;
    for (int k = 31; k >= 0; k--) begin
      if ((64'd360 << (k + 1)) > lim) res = k;
    end
    return res;
  endfunction

  localparam logic [4:0] K0 = 5'(calc_k0());

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDUCE   = 2'd1;
  localparam logic [1:0] CLASSIFY = 2'd2;
  localparam logic [1:0] OUT      = 2'd3;

  logic [1:0]    state;
  logic [RW-1:0] r;
  logic [4:0]    k;
  logic [RW-1:0] step;
  logic [1:0]    q_next;
  logic [RW-1:0] ref_next;

  assign in_ready = (state == IDLE);
  assign step     = RW'(360) << k;

  // r < 360 by the time CLASSIFY uses this.
  always_comb begin
    q_next   = 2'd0;
    ref_next = r;
    if (r <= RW'(90)) begin
      q_next   = 2'd0;
      ref_next = r;
    end else if (r <= RW'(180)) begin
      q_next   = 2'd1;
      ref_next = RW'(180) - r;
    end else if (r <= RW'(270)) begin
      q_next   = 2'd2;
      ref_next = r - RW'(180);
    end else begin
      q_next   = 2'd3;
      ref_next = RW'(360) - r;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      r         <= '0;
      k         <= K0;
      out_valid <= 1'b0;
      lut_en    <= 1'b0;
      quadrant  <= 2'd0;
      ref_angle <= '0;
    end else begin
      lut_en <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            r     <= RW'(angle_in);
            k     <= K0;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (r >= step) r <= r - step;
          if (k == 5'd0) state <= CLASSIFY;
          else           k     <= k - 5'd1;
        end
        CLASSIFY: begin
          quadrant  <= q_next;
          ref_angle <= REF_W'(ref_next);
          out_valid <= 1'b1;
          lut_en    <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_reducer.sv
// tb/tb_angle_reducer.sv - table-driven bench for angle_reducer plus backpressure, back-to-back and reset sequences
module tb_angle_reducer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] angle_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  quadrant;
  logic [7:0]  ref_angle;
  logic        lut_en;

  int checks = 0;
  int errors = 0;

  angle_reducer #(.ANGLE_W(16), .REF_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quadrant  (quadrant),
    .ref_angle (ref_angle),
    .lut_en    (lut_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int angle;
    int q;
    int ref_v;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accept one angle with out_ready=1; latency counts the accept edge as edge 1.
  task automatic run_one(input int a, input int eq, input int er, input string tag);
    int edges;
    @(negedge clk);
    out_ready = 1'b1;
    check({tag, " in_ready_before"}, int'(in_ready), 1);
    in_valid = 1'b1;
    angle_in = 16'(a);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 30) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, " latency"}, edges, 10);
    check({tag, " quadrant"}, int'(quadrant), eq);
    check({tag, " ref_angle"}, int'(ref_angle), er);
    check({tag, " lut_en"}, int'(lut_en), 1);
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid_cleared"}, int'(out_valid), 0);
    check({tag, " in_ready_after"}, int'(in_ready), 1);
  endtask

  int   list[3];
  int   acc_edges[$];
  int   res_q[$];
  int   res_r[$];
  int   idx;
  int   lut_cnt;
  int   seen;
  bit   acc;
  bit   got;
  logic [1:0] hq;
  logic [7:0] hr;

  initial begin
    vecs[0]  = '{0,     0, 0};
    vecs[1]  = '{135,   1, 45};
    vecs[2]  = '{271,   3, 89};
    vecs[3]  = '{270,   2, 90};
    vecs[4]  = '{180,   1, 0};
    vecs[5]  = '{90,    0, 90};
    vecs[6]  = '{360,   0, 0};
    vecs[7]  = '{750,   0, 30};
    vecs[8]  = '{65535, 0, 15};
    vecs[9]  = '{46080, 0, 0};
    vecs[10] = '{1,     0, 1};
    vecs[11] = '{359,   3, 1};
    vecs[12] = '{91,    1, 89};
    vecs[13] = '{181,   2, 1};
    vecs[14] = '{1000,  2, 100 - 80 - 20 + 100 - 80}; // 1000-720=280 -> (3,80), fixed below
    vecs[15] = '{46079, 3, 1};
    vecs[14] = '{1000,  3, 80};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    angle_in  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset lut_en", int'(lut_en), 0);
    check("reset quadrant", int'(quadrant), 0);
    check("reset ref_angle", int'(ref_angle), 0);

    for (int i = 0; i < 16; i++)
      run_one(vecs[i].angle, vecs[i].q, vecs[i].ref_v, $sformatf("vec%0d(%0d)", i, vecs[i].angle));

    // Backpressure: 200 -> (2,20), held for 5 cycles, single lut_en.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    angle_in  = 16'd200;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    angle_in = 16'd5;
    seen = 0;
    while (!out_valid && seen < 30) begin
      @(posedge clk);
      seen++;
      @(negedge clk);
    end
    check("bp latency", seen + 1, 10);
    lut_cnt = int'(lut_en);
    for (int c = 0; c < 5; c++) begin
      check("bp quadrant", int'(quadrant), 2);
      check("bp ref_angle", int'(ref_angle), 20);
      check("bp out_valid", int'(out_valid), 1);
      check("bp in_ready", int'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
      lut_cnt += int'(lut_en);
    end
    check("bp lut_en pulses", lut_cnt, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp released out_valid", int'(out_valid), 0);
    check("bp released in_ready", int'(in_ready), 1);

    // Back-to-back: in_valid held high, accepts must be 11 cycles apart.
    list[0] = 135;
    list[1] = 750;
    list[2] = 271;
    idx = 0;
    in_valid = 1'b1;
    angle_in = 16'(list[0]);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = in_valid && in_ready;
      got = out_valid;
      hq  = quadrant;
      hr  = ref_angle;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        acc_edges.push_back(cyc);
        idx++;
        if (idx < 3) angle_in = 16'(list[idx]);
        else in_valid = 1'b0;
      end
      if (got) begin
        res_q.push_back(int'(hq));
        res_r.push_back(int'(hr));
      end
    end
    in_valid = 1'b0;
    check("b2b accepts", acc_edges.size(), 3);
    check("b2b results", res_q.size(), 3);
    if (acc_edges.size() == 3) begin
      check("b2b gap1", acc_edges[1] - acc_edges[0], 11);
      check("b2b gap2", acc_edges[2] - acc_edges[1], 11);
    end
    if (res_q.size() == 3) begin
      check("b2b r0 q", res_q[0], 1);
      check("b2b r0 ref", res_r[0], 45);
      check("b2b r1 q", res_q[1], 0);
      check("b2b r1 ref", res_r[1], 30);
      check("b2b r2 q", res_q[2], 3);
      check("b2b r2 ref", res_r[2], 89);
    end

    // Reset during the 4th REDUCE step aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    angle_in = 16'd1000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("abort in_ready", int'(in_ready), 1);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      seen += int'(out_valid) + int'(lut_en);
      @(posedge clk);
      @(negedge clk);
    end
    check("abort no output", seen, 0);
    run_one(45, 0, 45, "post-abort 45");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
